powlib_iparbiter: RTL

- N-input round-robin arbiter multiplexing packed intr0 words {op, be, data} from several requesters onto one intr0 output stream.
- Holds a grant for up to B_MAX consecutive beats (burst tenure) before rotating.
- Registered output with valid/ready flow control.
- Sits between multiple intr0 producers (bus masters, DMA channels) and a shared intr0 consumer.

---
 rtl/powlib_iparbiter_if.sv | 34 +++
 rtl/powlib_iparbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/powlib_iparbiter_if.sv
// Handshake bundle between N intr0 requesters and one intr0 consumer.
// Carries no logic; slave is the arbiter's view, master the surrounding system's.
`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 1
`endif

interface powlib_iparbiter_if #(
    parameter int B_BPD = 4,
    parameter int N     = 2
);
    localparam int B_WW = `POWLIB_BW*B_BPD + B_BPD + `POWLIB_OPW;
    localparam int B_SW = $clog2(N);

    logic [N*B_WW-1:0] wrdata;
    logic [N-1:0]      wrvld;
    logic [N-1:0]      wrrdy;
    logic [B_WW-1:0]   rddata;
    logic              rdvld;
    logic              rdrdy;
    logic [B_SW-1:0]   rdsel;

    modport slave (
        input  wrdata, wrvld, rdrdy,
        output wrrdy, rddata, rdvld, rdsel
    );

    modport master (
        output wrdata, wrvld, rdrdy,
        input  wrrdy, rddata, rdvld, rdsel
    );
endinterface

// File: rtl/powlib_iparbiter.sv
// Round-robin N-to-1 intr0 arbiter with bounded burst tenure (B_MAX beats per grant).
// Latency: one cycle from acceptance to rdvld; sustains one beat per cycle.
// Backpressure: a full output stage with rdrdy low freezes all state and deasserts every wrrdy.
`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 1
`endif

module powlib_iparbiter #(
    parameter int B_BPD = 4,
    parameter int N     = 2,
    parameter int B_MAX = 4
) (
    input logic            clk,
    input logic            rst,
    powlib_iparbiter_if.slave bus
);
    localparam int B_WW = `POWLIB_BW*B_BPD + B_BPD + `POWLIB_OPW;
    localparam int B_SW = $clog2(N);

    logic [B_WW-1:0] rddata_q;
    logic            rdvld_q;
    logic [B_SW-1:0] rdsel_q;
    logic [B_SW-1:0] cur;
    logic [3:0]      cnt;

    logic            ld;
    logic            gnt;
    logic            cont;
    logic [B_SW-1:0] sel;
    logic [N-1:0]    wrrdy_w;

    always_comb begin
        ld   = !rdvld_q || bus.rdrdy;
        cont = (cnt != 4'd0) && (cnt < 4'(B_MAX)) && bus.wrvld[cur];
        gnt  = |bus.wrvld;
        sel  = cur;
        if (!cont) begin
            // Walk from the farthest candidate back to cur+1 so the nearest valid
            // requester wins; cur itself (k==N) is considered last.
            for (int k = N; k >= 1; k--) begin
                if (bus.wrvld[(int'(cur) + k) % N]) begin
                    sel = B_SW'((int'(cur) + k) % N);
                end
            end
        end
    end

    always_comb begin
        wrrdy_w = '0;
        if (rst && ld && gnt) begin
            wrrdy_w[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rddata_q <= '0;
            rdvld_q  <= 1'b0;
            rdsel_q  <= '0;
            cur      <= B_SW'(N-1);
            cnt      <= 4'd0;
        end else if (ld) begin
            if (gnt) begin
                rddata_q <= bus.wrdata[int'(sel)*B_WW +: B_WW];
                rdsel_q  <= sel;
                rdvld_q  <= 1'b1;
                cnt      <= cont ? cnt + 4'd1 : 4'd1;
                cur      <= sel;
            end else begin
                rdvld_q  <= 1'b0;
                cnt      <= 4'd0;
            end
        end
    end

    assign bus.wrrdy  = wrrdy_w;
    assign bus.rddata = rddata_q;
    assign bus.rdvld  = rdvld_q;
    assign bus.rdsel  = rdsel_q;
endmodule
